laser_point_feeder: RTL and testbench
=====================================

// Module: laser_point_feeder
// PURPOSE
//  Host-side driver for the LASER circle-cover engine. Buffers NPTS target points
//  written by the host, resets the engine, streams the points on X/Y one per cycle,
//  waits for DONE, captures C1X/C1Y/C2X/C2Y and returns them on a valid/ready port.
//  Sits between the host/testbench and the LASER engine (engine reset: sync, active-high).
// PARAMETERS
//  NPTS    40     points per job; must match engine fetch count
//  CW      4      coordinate width
//  TW      16     watchdog counter width
//  TIMEOUT 40000  max WAIT cycles before error (used only with LPF_WATCHDOG_EN)
// PORTS
//  CLK        in  1   clock, all logic rising-edge
//  RST_N      in  1   asynchronous active-low reset
//  LD_VALID   in  1   host point write valid
//  LD_READY   out 1   feeder can accept a point
//  LD_X/LD_Y  in  CW  point coordinates
//  START      in  1   single-cycle job start request
//  BUSY       out 1   1 in FEED, WAIT, RESULT
//  ENG_RST    out 1   engine reset, registered, active-high
//  ENG_X/Y    out CW  streamed point to engine, registered
//  ENG_DONE   in  1   engine completion pulse
//  ENG_C1X/C1Y/C2X/C2Y  in CW  engine results, valid in the ENG_DONE cycle
//  RES_VALID  out 1   result available
//  RES_READY  in  1   host accepts result
//  RES_C1X/C1Y/C2X/C2Y  out CW  captured results
//  ERR        out 1   watchdog error flag (constant 0 without LPF_WATCHDOG_EN)
// BEHAVIOUR
//  Reset: state=IDLE, lcnt=0, fcnt=0, ENG_RST=1, ENG_X/Y=0, RES_VALID=0, RES_C*=0,
//   ERR=0, LD_READY=1, BUSY=0. Point buffer not reset.
//  States: IDLE -> FEED -> WAIT -> RESULT -> IDLE.
//  IDLE: LD_READY = (lcnt<NPTS). LD_VALID&LD_READY writes buf[lcnt], lcnt++.
//   LD_VALID when lcnt==NPTS dropped. ENG_RST=1 throughout.
//   START with lcnt==NPTS -> FEED; on that edge ENG_RST<=0, ENG_X/Y<=buf[0].
//   START with lcnt<NPTS ignored (no state change, no error).
//  FEED: NPTS cycles, k=0..NPTS-1, ENG_RST=0, ENG_X/Y=buf[k] in cycle k;
//   after k=NPTS-1 -> WAIT, ENG_X/Y<=0. LD_READY=0.
//  WAIT: ENG_RST=0, ENG_X/Y=0. ENG_DONE=1 -> capture ENG_C* into RES_C*,
//   ENG_RST<=1, RES_VALID<=1, -> RESULT. Results appear 1 cycle after ENG_DONE.
//  ENG_DONE in IDLE, FEED or RESULT ignored; no capture.
//  RESULT: RES_VALID=1, RES_C* stable until RES_VALID&RES_READY; then RES_VALID<=0,
//   lcnt<=0, -> IDLE (buffer must be reloaded). Same-cycle START ignored.
//  ENG_RST held 1 in IDLE and RESULT: engine sees reset >=1 cycle before each job
//   and does not self-restart after DONE.
//  fcnt width $clog2(NPTS); no wrap beyond NPTS-1. lcnt saturates at NPTS.
//  RST_N low in any state: immediate return to reset values, job discarded.
// CONFIGURATION
//  LPF_WATCHDOG_EN defined: TW-bit counter cleared on WAIT entry, increments each
//   WAIT cycle; reaching TIMEOUT without ENG_DONE -> ERR<=1, RES_C*<=0,
//   RES_VALID<=1, ENG_RST<=1, -> RESULT. ERR clears on next accepted START.
//   ENG_DONE in the timeout cycle wins (normal capture, ERR stays 0).
//  Not defined: no counter, ERR tied 0, WAIT indefinitely.
// TESTING
//  1 Load 40x(3,3), START; engine model DONE 100 cycles after FEED with C1=(3,3),
//    C2=(4,4) -> ENG_RST low exactly 40 FEED+100 WAIT cycles, ENG_X=3 all FEED
//    cycles, RES_VALID next cycle with C1=(3,3),C2=(4,4).
//  2 Load 39 points, START -> ignored, BUSY=0, LD_READY=1; 40th load -> LD_READY=0.
//  3 RES_READY low 10 cycles in RESULT -> RES_VALID/RES_C* stable, LD_READY=0;
//    RES_READY high -> IDLE, LD_READY=1, lcnt=0.
//  4 RST_N low at FEED k=17 -> ENG_RST=1, ENG_X=0, BUSY=0 immediately; START ignored
//    until 40 points reloaded.
//  5 ENG_DONE pulse during FEED k=5 and in IDLE -> ignored, RES_VALID stays 0.
//  6 LPF_WATCHDOG_EN, TIMEOUT=50, no DONE -> after 50 WAIT cycles ERR=1,
//    RES_VALID=1, RES_C*=0; next START clears ERR.

Source files
------------

// File: rtl/laser_point_feeder_if.sv
// Host/engine signal bundle for laser_point_feeder: point load port, job control,
// engine stream/result port and the valid/ready result port.
interface laser_point_feeder_if #(
  parameter int CW = 4
);
  logic          LD_VALID;
  logic          LD_READY;
  logic [CW-1:0] LD_X;
  logic [CW-1:0] LD_Y;
  logic          START;
  logic          BUSY;
  logic          ENG_RST;
  logic [CW-1:0] ENG_X;
  logic [CW-1:0] ENG_Y;
  logic          ENG_DONE;
  logic [CW-1:0] ENG_C1X;
  logic [CW-1:0] ENG_C1Y;
  logic [CW-1:0] ENG_C2X;
  logic [CW-1:0] ENG_C2Y;
  logic          RES_VALID;
  logic          RES_READY;
  logic [CW-1:0] RES_C1X;
  logic [CW-1:0] RES_C1Y;
  logic [CW-1:0] RES_C2X;
  logic [CW-1:0] RES_C2Y;
  logic          ERR;

  modport master (
    output LD_VALID, LD_X, LD_Y, START, ENG_DONE, ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y, RES_READY,
    input  LD_READY, BUSY, ENG_RST, ENG_X, ENG_Y, RES_VALID, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, ERR
  );

  modport slave (
    input  LD_VALID, LD_X, LD_Y, START, ENG_DONE, ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y, RES_READY,
    output LD_READY, BUSY, ENG_RST, ENG_X, ENG_Y, RES_VALID, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, ERR
  );
endinterface

// File: rtl/laser_point_feeder.sv
// Host-side driver for the LASER circle-cover engine: buffers NPTS points, streams them,
// waits for DONE and returns the captured circles. Optional watchdog: LPF_WATCHDOG_EN.
module laser_point_feeder #(
  parameter int NPTS    = 40,
  parameter int CW      = 4,
  parameter int TW      = 16,
  parameter int TIMEOUT = 40000
) (
  input  logic               CLK,
  input  logic               RST_N,
  laser_point_feeder_if.slave bus
);

  localparam int LW = $clog2(NPTS + 1);
  localparam int FW = $clog2(NPTS);

  if (NPTS < 2) begin : g_bad_npts
    $error("laser_point_feeder: NPTS must be at least 2");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (64'd1 << TW)) begin : g_bad_timeout
    $error("laser_point_feeder: TIMEOUT must fit in TW bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_RESULT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LW-1:0]   lcnt;
  logic [FW-1:0]   fcnt;
  logic [FW-1:0]   fidx;
  logic            full;
  logic            load_en;
  logic            start_acc;
  logic            feed_last;
  logic            done_acc;
  logic            res_acc;
  logic            wd_hit;
  logic            wd_expired;

  logic [CW-1:0]   buf_x [NPTS];
  logic [CW-1:0]   buf_y [NPTS];

  logic            eng_rst_p0;
  logic [CW-1:0]   eng_x_p0;
  logic [CW-1:0]   eng_y_p0;
  logic            res_vld_p0;
  logic [CW-1:0]   res_c1x_p0;
  logic [CW-1:0]   res_c1y_p0;
  logic [CW-1:0]   res_c2x_p0;
  logic [CW-1:0]   res_c2y_p0;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == LW'(NPTS)) ? v : v + LW'(1);
  endfunction

  assign full = (lcnt == LW'(NPTS));
  assign fidx = fcnt + FW'(1);

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    start_acc = 1'b0;
    feed_last = 1'b0;
    done_acc  = 1'b0;
    res_acc   = 1'b0;
    wd_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        load_en = bus.LD_VALID && !full;
        if (bus.START && full) begin
          start_acc = 1'b1;
          state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        if (fcnt == FW'(NPTS - 1)) begin
          feed_last = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A DONE arriving in the timeout cycle still wins over the watchdog
        if (bus.ENG_DONE) begin
          done_acc  = 1'b1;
          state_nxt = S_RESULT;
        end else if (wd_expired) begin
          wd_hit    = 1'b1;
          state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        if (bus.RES_READY) begin
          res_acc   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Point buffer: written only while loading, never reset
  always_ff @(posedge CLK) begin
    if (load_en) begin
      buf_x[lcnt] <= bus.LD_X;
      buf_y[lcnt] <= bus.LD_Y;
    end
  end

  // Stage p0: registered engine drive and captured results
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lcnt       <= '0;
      fcnt       <= '0;
      eng_rst_p0 <= 1'b1;
      eng_x_p0   <= '0;
      eng_y_p0   <= '0;
      res_vld_p0 <= 1'b0;
      res_c1x_p0 <= '0;
      res_c1y_p0 <= '0;
      res_c2x_p0 <= '0;
      res_c2y_p0 <= '0;
    end else begin
      if (res_acc)      lcnt <= '0;
      else if (load_en) lcnt <= sat_inc(lcnt);

      if (start_acc)                         fcnt <= '0;
      else if (state == S_FEED && !feed_last) fcnt <= fidx;

      if (start_acc)               eng_rst_p0 <= 1'b0;
      else if (done_acc || wd_hit) eng_rst_p0 <= 1'b1;

      if (start_acc) begin
        eng_x_p0 <= buf_x[0];
        eng_y_p0 <= buf_y[0];
      end else if (state == S_FEED) begin
        if (feed_last) begin
          eng_x_p0 <= '0;
          eng_y_p0 <= '0;
        end else begin
          eng_x_p0 <= buf_x[fidx];
          eng_y_p0 <= buf_y[fidx];
        end
      end

      if (done_acc) begin
        res_vld_p0 <= 1'b1;
        res_c1x_p0 <= bus.ENG_C1X;
        res_c1y_p0 <= bus.ENG_C1Y;
        res_c2x_p0 <= bus.ENG_C2X;
        res_c2y_p0 <= bus.ENG_C2Y;
      end else if (wd_hit) begin
        res_vld_p0 <= 1'b1;
        res_c1x_p0 <= '0;
        res_c1y_p0 <= '0;
        res_c2x_p0 <= '0;
        res_c2y_p0 <= '0;
      end else if (res_acc) begin
        res_vld_p0 <= 1'b0;
      end
    end
  end

`ifdef LPF_WATCHDOG_EN
  logic [TW-1:0] wd_cnt;
  logic          err_p0;

  assign wd_expired = (wd_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt <= '0;
      err_p0 <= 1'b0;
    end else begin
      if (feed_last)             wd_cnt <= '0;
      else if (state == S_WAIT)  wd_cnt <= wd_cnt + TW'(1);

      if (wd_hit)         err_p0 <= 1'b1;
      else if (start_acc) err_p0 <= 1'b0;
    end
  end

  assign bus.ERR = err_p0;
`else
  assign wd_expired = 1'b0;
  assign bus.ERR    = 1'b0;
`endif

  assign bus.LD_READY  = (state == S_IDLE) && !full;
  assign bus.BUSY      = (state != S_IDLE);
  assign bus.ENG_RST   = eng_rst_p0;
  assign bus.ENG_X     = eng_x_p0;
  assign bus.ENG_Y     = eng_y_p0;
  assign bus.RES_VALID = res_vld_p0;
  assign bus.RES_C1X   = res_c1x_p0;
  assign bus.RES_C1Y   = res_c1y_p0;
  assign bus.RES_C2X   = res_c2x_p0;
  assign bus.RES_C2Y   = res_c2y_p0;

endmodule

// File: tb/tb_laser_point_feeder.sv
// Self-checking bench for laser_point_feeder: job-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_laser_point_feeder;
  localparam int NPTS = 40;
  localparam int CW   = 4;
  localparam int TW   = 16;
`ifdef LPF_WATCHDOG_EN
  localparam int TIMEOUT = 50;
  localparam bit WD_ON   = 1'b1;
`else
  localparam int TIMEOUT = 40000;
  localparam bit WD_ON   = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  laser_point_feeder_if #(.CW(CW)) bus();

  laser_point_feeder #(.NPTS(NPTS), .CW(CW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: phase 0 idle, 1 feeding, 2 waiting for engine, 3 result held
  int m_phase = 0;
  int m_n     = 0;
  int m_k     = 0;
  int m_wd    = 0;
  bit m_err   = 1'b0;
  bit m_rv    = 1'b0;
  int m_c1x = 0, m_c1y = 0, m_c2x = 0, m_c2y = 0;
  int m_px [NPTS];
  int m_py [NPTS];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_phase <= 0; m_n <= 0; m_k <= 0; m_wd <= 0; m_err <= 1'b0; m_rv <= 1'b0;
      m_c1x <= 0; m_c1y <= 0; m_c2x <= 0; m_c2y <= 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.LD_VALID && m_n < NPTS) begin
            m_px[m_n] <= int'(bus.LD_X);
            m_py[m_n] <= int'(bus.LD_Y);
            m_n <= m_n + 1;
          end
          if (bus.START && m_n == NPTS) begin
            m_phase <= 1; m_k <= 0; m_err <= 1'b0;
          end
        end
        1: begin
          if (m_k == NPTS - 1) begin m_phase <= 2; m_wd <= 0; end
          else m_k <= m_k + 1;
        end
        2: begin
          if (bus.ENG_DONE) begin
            m_c1x <= int'(bus.ENG_C1X); m_c1y <= int'(bus.ENG_C1Y);
            m_c2x <= int'(bus.ENG_C2X); m_c2y <= int'(bus.ENG_C2Y);
            m_rv <= 1'b1; m_phase <= 3;
          end else if (WD_ON && m_wd == TIMEOUT - 1) begin
            m_c1x <= 0; m_c1y <= 0; m_c2x <= 0; m_c2y <= 0;
            m_err <= 1'b1; m_rv <= 1'b1; m_phase <= 3;
          end else begin
            m_wd <= m_wd + 1;
          end
        end
        default: begin
          if (bus.RES_READY) begin m_rv <= 1'b0; m_n <= 0; m_phase <= 0; end
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ld_ready",  bus.LD_READY,  (m_phase == 0 && m_n < NPTS));
      chk("busy",      bus.BUSY,      (m_phase != 0));
      chk("eng_rst",   bus.ENG_RST,   (m_phase == 0 || m_phase == 3));
      chk("eng_x",     bus.ENG_X,     (m_phase == 1) ? m_px[m_k] : 0);
      chk("eng_y",     bus.ENG_Y,     (m_phase == 1) ? m_py[m_k] : 0);
      chk("res_valid", bus.RES_VALID, m_rv);
      chk("res_c1x",   bus.RES_C1X,   m_c1x);
      chk("res_c1y",   bus.RES_C1Y,   m_c1y);
      chk("res_c2x",   bus.RES_C2X,   m_c2x);
      chk("res_c2y",   bus.RES_C2Y,   m_c2y);
      chk("err",       bus.ERR,       m_err);
    end
  end

  int rst_low_cnt = 0;
  always @(negedge CLK) if (bus.ENG_RST === 1'b0) rst_low_cnt <= rst_low_cnt + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_pt(input int x, input int y);
    bus.LD_VALID = 1'b1;
    bus.LD_X = CW'(x);
    bus.LD_Y = CW'(y);
    tick();
    bus.LD_VALID = 1'b0;
  endtask

  task automatic start_job();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic done_pulse(input int c1x, input int c1y, input int c2x, input int c2y);
    bus.ENG_DONE = 1'b1;
    bus.ENG_C1X = CW'(c1x); bus.ENG_C1Y = CW'(c1y);
    bus.ENG_C2X = CW'(c2x); bus.ENG_C2Y = CW'(c2y);
    tick();
    bus.ENG_DONE = 1'b0;
    bus.ENG_C1X = 4'd9; bus.ENG_C1Y = 4'd9; bus.ENG_C2X = 4'd9; bus.ENG_C2Y = 4'd9;
  endtask

  task automatic accept_result();
    bus.RES_READY = 1'b1;
    tick();
    bus.RES_READY = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n0;
    bus.LD_VALID = 1'b0; bus.LD_X = '0; bus.LD_Y = '0; bus.START = 1'b0;
    bus.ENG_DONE = 1'b0; bus.ENG_C1X = '0; bus.ENG_C1Y = '0; bus.ENG_C2X = '0; bus.ENG_C2Y = '0;
    bus.RES_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_eng_rst",   bus.ENG_RST,   1);
    chk("reset_ld_ready",  bus.LD_READY,  1);
    chk("reset_busy",      bus.BUSY,      0);
    chk("reset_res_valid", bus.RES_VALID, 0);
    chk("reset_eng_x",     bus.ENG_X,     0);
    chk("reset_err",       bus.ERR,       0);
    RST_N  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Basic job: 40 x (3,3), engine answers 100 cycles into WAIT
    for (int i = 0; i < NPTS; i++) load_pt(3, 3);
    n0 = rst_low_cnt;
    start_job();
    chk("t1_eng_x_k0", bus.ENG_X, 3);
    repeat (NPTS) tick();
    repeat (99) tick();
    done_pulse(3, 3, 4, 4);
    chk("t1_res_valid", bus.RES_VALID, 1);
    chk("t1_c1x", bus.RES_C1X, 3);
    chk("t1_c1y", bus.RES_C1Y, 3);
    chk("t1_c2x", bus.RES_C2X, 4);
    chk("t1_c2y", bus.RES_C2Y, 4);
    chk("t1_rst_low_cycles", rst_low_cnt - n0, 140);
    accept_result();
    chk("t1_idle_busy", bus.BUSY, 0);
    chk("t1_idle_ld_ready", bus.LD_READY, 1);

    // Partial buffer: START ignored; DONE in IDLE ignored; full buffer drops loads
    for (int i = 0; i < NPTS - 1; i++) load_pt(i % 16, 15 - (i % 16));
    start_job();
    chk("t2_start_ignored_busy", bus.BUSY, 0);
    chk("t2_ld_ready_39", bus.LD_READY, 1);
    done_pulse(1, 1, 1, 1);
    chk("t5_idle_done_res_valid", bus.RES_VALID, 0);
    load_pt(7, 2);
    chk("t2_ld_ready_40", bus.LD_READY, 0);
    load_pt(15, 15);
    chk("t2_ld_ready_after_drop", bus.LD_READY, 0);
    start_job();
    repeat (5) tick();
    done_pulse(1, 1, 1, 1);
    chk("t5_feed_done_res_valid", bus.RES_VALID, 0);
    chk("t5_feed_done_busy", bus.BUSY, 1);
    repeat (34) tick();
    chk("t2_wait_eng_rst", bus.ENG_RST, 0);
    chk("t2_wait_eng_x", bus.ENG_X, 0);
    repeat (3) tick();
    done_pulse(5, 6, 7, 8);

    // Result held while host stalls
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", bus.RES_VALID, 1);
      chk("t3_hold_c1x", bus.RES_C1X, 5);
      chk("t3_hold_c1y", bus.RES_C1Y, 6);
      chk("t3_hold_c2x", bus.RES_C2X, 7);
      chk("t3_hold_c2y", bus.RES_C2Y, 8);
      chk("t3_hold_ld_ready", bus.LD_READY, 0);
      tick();
    end
    bus.START = 1'b1;
    accept_result();
    bus.START = 1'b0;
    chk("t3_accept_busy", bus.BUSY, 0);
    chk("t3_accept_ld_ready", bus.LD_READY, 1);
    chk("t3_accept_valid", bus.RES_VALID, 0);
    start_job();
    chk("t3_reload_needed_busy", bus.BUSY, 0);

    // Asynchronous reset in the middle of FEED
    for (int i = 0; i < NPTS; i++) load_pt((i * 3) % 16, (i * 5) % 16);
    start_job();
    repeat (17) tick();
    RST_N = 1'b0;
    #1;
    chk("t4_eng_rst", bus.ENG_RST, 1);
    chk("t4_eng_x", bus.ENG_X, 0);
    chk("t4_eng_y", bus.ENG_Y, 0);
    chk("t4_busy", bus.BUSY, 0);
    tick();
    RST_N = 1'b1;
    start_job();
    chk("t4_start_ignored", bus.BUSY, 0);
    for (int i = 0; i < NPTS; i++) load_pt(i % 16, (i + 1) % 16);
    start_job();
    chk("t4_reload_busy", bus.BUSY, 1);
    repeat (NPTS) tick();
    done_pulse(2, 10, 12, 14);
    chk("t4_c1y", bus.RES_C1Y, 10);
    accept_result();

`ifdef LPF_WATCHDOG_EN
    // Watchdog expiry, ERR clear on next START, DONE winning the timeout cycle
    for (int i = 0; i < NPTS; i++) load_pt(1, 1);
    start_job();
    repeat (NPTS) tick();
    repeat (TIMEOUT - 1) tick();
    chk("t6_before_err", bus.ERR, 0);
    chk("t6_before_valid", bus.RES_VALID, 0);
    tick();
    chk("t6_err", bus.ERR, 1);
    chk("t6_valid", bus.RES_VALID, 1);
    chk("t6_c1x", bus.RES_C1X, 0);
    chk("t6_c2y", bus.RES_C2Y, 0);
    accept_result();
    chk("t6_err_kept", bus.ERR, 1);
    for (int i = 0; i < NPTS; i++) load_pt(2, 2);
    start_job();
    chk("t6_err_cleared", bus.ERR, 0);
    repeat (NPTS) tick();
    repeat (TIMEOUT - 1) tick();
    done_pulse(1, 2, 3, 4);
    chk("t6_done_wins_err", bus.ERR, 0);
    chk("t6_done_wins_c1x", bus.RES_C1X, 1);
    accept_result();
`endif

    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
